risc_fetch: RTL and testbench
=============================

# risc_fetch

Instruction fetch stage of the RiSC-16 core, directly upstream of `control`. It owns the program counter, fetches one 16-bit instruction word at a time over a request/acknowledge instruction-memory port, and holds it in an instruction register. It presents the decoded fields, including `opcode` for `control`, until the datapath retires the instruction. On retirement it computes the next PC from the `mux_pc` select produced by `control`.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  16  word address of the fetch, equal to `pc`.
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  16  instruction word.
- `inst_valid`  out  1  instruction register holds a live instruction.
- `opcode`  out  3  IR[15:13].
- `reg_a`, `reg_b`, `reg_c`  out  3 each  IR[12:10], IR[9:7], IR[2:0].
- `simm`  out  16  IR[6:0], sign-extended.
- `imm_hi`  out  16  {IR[9:0], 6'b0} (LUI operand).
- `pc`  out  16  address of the current instruction.
- `pc_plus1`  out  16  `pc` + 1, modulo 2^16 (JALR link value).
- `exec_done`  in  1  datapath retires the current instruction this cycle.
- `mux_pc`  in  2  next-PC select from `control`.
- `jalr_tgt`  in  16  register rB value for JALR.
- `halted`  out  1  a halt instruction has retired; fetch has stopped.

## Operation
- States: FETCH (`imem_req`=1), HOLD (`inst_valid`=1), HALT (`halted`=1).
- FETCH:
  - When `imem_ack`=1 at an edge, capture `imem_rdata` into IR and go to HOLD.
  - `imem_addr` stays stable while in FETCH.
- HOLD:
  - IR and `pc` are frozen.
  - On `exec_done`=1:
    - If the instruction is a halt, go to HALT.
    - Otherwise load `pc` with the next PC and go to FETCH.
- Next-PC select (`mux_pc`):
  - 0: `pc`+1.
  - 1: `pc`+1+`simm` (BEQ taken).
  - 2: `jalr_tgt`.
  - 3: reserved; behaves as 0.
- All PC arithmetic is 16-bit and wraps modulo 2^16 (FFFF+1 → 0000).
- Halt is `opcode`=3'b111 with IR[6:0] ≠ 0. HALT is left only by reset; `imem_req` stays 0 in HALT.
- Ignored inputs:
  - `exec_done` outside HOLD.
  - `imem_ack` outside FETCH, or while `imem_req`=0.
- Field outputs are combinational from IR and are meaningful only while `inst_valid`=1.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `pc`=`RESET_PC`, IR=0, state FETCH.
  - Reset applies mid-fetch and mid-hold alike; any in-flight instruction is discarded.
- Reset values of outputs:
  - `imem_req`=0 during the reset cycle. It is gated by a registered "out of reset" flag, so the first request appears the cycle after `rst_n` is sampled high.
  - `inst_valid`=0, `halted`=0.
- Fetch latency:
  - An ack in the same cycle `imem_req` rises is legal. `inst_valid` rises on the following cycle.
  - Minimum request-to-valid latency is 1 cycle; there is no upper bound.
- Retire to next request: `exec_done` at edge N gives `inst_valid`=0 and `imem_req`=1 with the new `imem_addr` in cycle N+1. Minimum per-instruction throughput is 2 cycles.
- `mux_pc` and `jalr_tgt` are sampled only on the `exec_done` edge.
- `imem_req` and `inst_valid` are never high in the same cycle.

## Structure
- Shared package `risc_pkg` holds:
  - Opcode constants: OP_ADD=0, OP_ADDI=1, OP_NAND=2, OP_LUI=3, OP_SW=4, OP_LW=5, OP_BEQ=6, OP_JALR=7.
  - `mux_pc` encodings: PC_INC=0, PC_BR=1, PC_JALR=2.
  - The fetch state enum.
  - Instruction field bit positions.
  - `control` is to import the same package.
- Sub-module `risc_decode_fields`: combinational IR → `opcode`, `reg_a`, `reg_b`, `reg_c`, `simm`, `imm_hi`, plus the `is_halt` flag. It is reused by the testbench reference model.
- Top-level `risc_fetch` contains the FSM, PC register, IR and next-PC adder.

## Test plan
- Reset release, `RESET_PC`=0, memory acks after 3 cycles with 16'h2482:
  - `imem_addr`=0 while requesting.
  - `inst_valid`=1 one cycle after the ack.
  - `opcode`=1, `reg_a`=1, `reg_b`=1, `simm`=2.
- Sequential flow: retire with `mux_pc`=0 at `pc`=0x0005 → next `imem_addr`=0x0006 one cycle later. With `pc`=0xFFFF → 0x0000 (wrap).
- Branch: `pc`=0x0010, IR=BEQ with simm7=7'h7E (−2), `mux_pc`=1 → next `pc`=0x000F. With `mux_pc`=3 → 0x0011.
- JALR: `mux_pc`=2, `jalr_tgt`=0x1234 → next `imem_addr`=0x1234. `pc_plus1` equals the old `pc`+1 while holding.
- Halt: retire 16'hE001 → `halted`=1 and `imem_req` stays 0 for 20 cycles. Asserting `rst_n`=0 restarts the fetch at `RESET_PC`.
- Reset mid-fetch and stray inputs:
  - `rst_n`=0 while `imem_req`=1 and unacked → `imem_req`=0 next cycle, `pc`=`RESET_PC`.
  - `exec_done` pulsed during FETCH → no PC change.
  - `imem_ack` pulsed during HOLD → IR unchanged.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared RiSC-16 definitions used by fetch, decode and control.
// Contents: opcode constants, next-PC select encodings, the fetch state enum,
// instruction field bit positions and an immediate sign-extension helper.
package risc_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JALR = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RA_MSB    = 12;
    localparam int RA_LSB    = 10;
    localparam int RB_MSB    = 9;
    localparam int RB_LSB    = 7;
    localparam int RC_MSB    = 2;
    localparam int RC_LSB    = 0;
    localparam int IMM7_MSB  = 6;
    localparam int IMM10_MSB = 9;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction
endpackage

// File: rtl/risc_decode_fields.sv
// risc_decode_fields: combinational split of an instruction word into its fields.
// Ports: ir (instruction word) -> opcode, reg_a, reg_b, reg_c, simm (sign-extended
// 7-bit immediate), imm_hi (LUI operand), is_halt (JALR encoding with nonzero imm).
module risc_decode_fields
    import risc_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [2:0]  reg_a,
    output logic [2:0]  reg_b,
    output logic [2:0]  reg_c,
    output logic [15:0] simm,
    output logic [15:0] imm_hi,
    output logic        is_halt
);
    assign opcode  = ir[OP_MSB:OP_LSB];
    assign reg_a   = ir[RA_MSB:RA_LSB];
    assign reg_b   = ir[RB_MSB:RB_LSB];
    assign reg_c   = ir[RC_MSB:RC_LSB];
    assign simm    = sext7(ir[IMM7_MSB:0]);
    assign imm_hi  = {ir[IMM10_MSB:0], 6'b0};
    // A JALR with a nonzero immediate field is the halt encoding.
    assign is_halt = (opcode == OP_JALR) && (ir[IMM7_MSB:0] != 7'd0);
endmodule

// File: rtl/risc_fetch.sv
// risc_fetch: RiSC-16 instruction fetch stage owning the PC and instruction register.
// Ports: clk/rst_n (sync active-low); imem_req/imem_addr/imem_ack/imem_rdata fetch port;
// inst_valid and decoded fields (opcode, reg_a/b/c, simm, imm_hi), pc, pc_plus1;
// exec_done/mux_pc/jalr_tgt retirement inputs; halted once a halt retires.
module risc_fetch
    import risc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [2:0]  opcode,
    output logic [2:0]  reg_a,
    output logic [2:0]  reg_b,
    output logic [2:0]  reg_c,
    output logic [15:0] simm,
    output logic [15:0] imm_hi,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    input  logic        exec_done,
    input  logic [1:0]  mux_pc,
    input  logic [15:0] jalr_tgt,
    output logic        halted
);
    fetch_state_t state;
    logic         run;
    logic [15:0]  ir;
    logic [15:0]  next_pc;
    logic         is_halt;

    risc_decode_fields u_dec (
        .ir      (ir),
        .opcode  (opcode),
        .reg_a   (reg_a),
        .reg_b   (reg_b),
        .reg_c   (reg_c),
        .simm    (simm),
        .imm_hi  (imm_hi),
        .is_halt (is_halt)
    );

    // run is the registered out-of-reset flag: it holds the first request off
    // until the cycle after rst_n is sampled high.
    assign imem_req   = run && (state == ST_FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == ST_HOLD);
    assign halted     = (state == ST_HALT);
    assign pc_plus1   = pc + 16'd1;

    // Reserved select 3 falls through to the sequential increment.
    always_comb
        next_pc = (mux_pc == PC_BR)   ? pc_plus1 + simm :
                  (mux_pc == PC_JALR) ? jalr_tgt : pc_plus1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            run   <= 1'b0;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            run <= 1'b1;
            case (state)
                ST_FETCH:
                    if (imem_req && imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_HOLD;
                    end
                ST_HOLD:
                    if (exec_done) begin
                        if (is_halt) begin
                            state <= ST_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= ST_FETCH;
                        end
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_fetch.sv
// tb_risc_fetch: scoreboard bench for risc_fetch with directed and random traffic.
module tb_risc_fetch;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        exec_done = 1'b0;
    logic [1:0]  mux_pc = 2'd0;
    logic [15:0] jalr_tgt = 16'h0000;
    logic        imem_req, inst_valid, halted;
    logic [15:0] imem_addr, simm, imm_hi, pc, pc_plus1;
    logic [2:0]  opcode, reg_a, reg_b, reg_c;

    risc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .opcode     (opcode),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .reg_c      (reg_c),
        .simm       (simm),
        .imm_hi     (imm_hi),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .exec_done  (exec_done),
        .mux_pc     (mux_pc),
        .jalr_tgt   (jalr_tgt),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
    } inst_t;

    int          errors = 0;
    int          checks = 0;
    inst_t       exp_q[$];
    logic [15:0] addr_q[$];
    logic [15:0] model_pc = RESET_PC;
    logic [15:0] model_ir = 16'h0000;
    bit          model_halted = 1'b0;
    bit          mon_on = 1'b0;
    inst_t       cur;
    logic [15:0] cur_addr = 16'h0000;
    bit          prev_req = 1'b0;
    bit          prev_valid = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_halt_m(input logic [15:0] w);
        return (w[15:13] == 3'b111) && (w[6:0] != 7'd0);
    endfunction

    function automatic int simm_m(input logic [15:0] w);
        int v = int'(w[6:0]);
        return (v >= 64) ? v - 128 : v;
    endfunction

    function automatic logic [15:0] next_pc_m(input logic [15:0] p, input logic [15:0] w,
                                              input logic [1:0] m, input logic [15:0] t);
        if (m == 2'd2) return t;
        if (m == 2'd1) return 16'((int'(p) + 1 + simm_m(w)) & 32'hFFFF);
        return 16'((int'(p) + 1) & 32'hFFFF);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a request or an instruction.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("req_and_valid", 16'(imem_req & inst_valid), 16'd0);
            chk("halted", 16'(halted), 16'(model_halted));
            if (model_halted) chk("halt_req", 16'(imem_req), 16'd0);
            if (imem_req && !prev_req) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL addr_q: unexpected request at %h", imem_addr);
                end else begin
                    cur_addr = addr_q.pop_front();
                end
            end
            if (imem_req) chk("imem_addr", imem_addr, cur_addr);
            if (inst_valid && !prev_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL exp_q: unexpected inst_valid, ir fields opcode=%h", opcode);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (inst_valid) begin
                chk("pc", pc, cur.pc);
                chk("pc_plus1", pc_plus1, 16'((int'(cur.pc) + 1) & 32'hFFFF));
                chk("opcode", 16'(opcode), 16'(cur.ir >> 13));
                chk("reg_a", 16'(reg_a), (cur.ir >> 10) & 16'd7);
                chk("reg_b", 16'(reg_b), (cur.ir >> 7) & 16'd7);
                chk("reg_c", 16'(reg_c), cur.ir & 16'd7);
                chk("simm", simm, 16'(simm_m(cur.ir) & 32'hFFFF));
                chk("imm_hi", imm_hi, 16'((int'(cur.ir) * 64) & 32'hFFFF));
            end
            prev_req   = imem_req;
            prev_valid = inst_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        exec_done = 1'b0;
        tick();
        mon_on = 1'b1;
        model_halted = 1'b0;
        exp_q.delete();
        addr_q.delete();
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_valid", 16'(inst_valid), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_pc", pc, RESET_PC);
        tick();
        model_pc = RESET_PC;
        addr_q.push_back(RESET_PC);
        rst_n = 1'b1;
        chk("req_held_off", 16'(imem_req), 16'd0);
        tick();
        chk("first_req", 16'(imem_req), 16'd1);
    endtask

    task automatic fetch(input logic [15:0] data, input int lat, input bit stray);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1", imem_req, n);
            return;
        end
        for (int i = 0; i < lat; i++) begin
            if (stray && i == 0) begin
                exec_done = 1'b1;
                mux_pc = 2'd2;
                jalr_tgt = 16'($urandom);
            end
            tick();
            exec_done = 1'b0;
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        model_ir = data;
        exp_q.push_back('{pc: model_pc, ir: data});
        tick();
        imem_ack = 1'b0;
        imem_rdata = 16'($urandom);
        chk("valid_after_ack", 16'(inst_valid), 16'd1);
    endtask

    task automatic retire(input logic [1:0] m, input logic [15:0] tgt, input int hold, input bit stray);
        for (int i = 0; i < hold; i++) begin
            if (stray) begin
                imem_ack = 1'b1;
                imem_rdata = ~model_ir;
            end
            mux_pc = 2'($urandom);
            jalr_tgt = 16'($urandom);
            tick();
            imem_ack = 1'b0;
        end
        exec_done = 1'b1;
        mux_pc = m;
        jalr_tgt = tgt;
        tick();
        exec_done = 1'b0;
        mux_pc = 2'($urandom);
        jalr_tgt = 16'($urandom);
        if (is_halt_m(model_ir)) begin
            model_halted = 1'b1;
            chk("halt_no_req", 16'(imem_req), 16'd0);
        end else begin
            model_pc = next_pc_m(model_pc, model_ir, m, tgt);
            addr_q.push_back(model_pc);
            chk("next_addr", imem_addr, model_pc);
            chk("next_req", 16'(imem_req), 16'd1);
            chk("next_valid", 16'(inst_valid), 16'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        do_reset();
        fetch(16'h2482, 3, 1'b0);
        chk("t1_opcode", 16'(opcode), 16'd1);
        chk("t1_reg_a", 16'(reg_a), 16'd1);
        chk("t1_reg_b", 16'(reg_b), 16'd1);
        chk("t1_simm", simm, 16'd2);
        retire(2'd2, 16'h0005, 1, 1'b0);
        fetch(16'h0000, 0, 1'b0);
        retire(2'd0, 16'h0000, 0, 1'b0);
        chk("seq_addr", imem_addr, 16'h0006);
        fetch(16'h0000, 2, 1'b1);
        retire(2'd2, 16'hFFFF, 2, 1'b1);
        fetch(16'h0000, 1, 1'b0);
        retire(2'd0, 16'h0000, 0, 1'b0);
        chk("wrap_addr", imem_addr, 16'h0000);
        fetch(16'h0000, 0, 1'b0);
        retire(2'd2, 16'h0010, 0, 1'b0);
        fetch(16'hC07E, 0, 1'b0);
        retire(2'd1, 16'h0000, 1, 1'b0);
        chk("beq_addr", imem_addr, 16'h000F);
        fetch(16'h0000, 0, 1'b0);
        retire(2'd2, 16'h0010, 0, 1'b0);
        fetch(16'hC07E, 0, 1'b0);
        retire(2'd3, 16'h0000, 0, 1'b0);
        chk("rsvd_addr", imem_addr, 16'h0011);
        fetch(16'hE000, 1, 1'b0);
        retire(2'd2, 16'h1234, 0, 1'b0);
        chk("jalr_addr", imem_addr, 16'h1234);
        fetch(16'h0000, 0, 1'b0);
        chk("jalr_link", pc_plus1, 16'h1235);
        retire(2'd2, 16'h1234, 0, 1'b0);
        tick();
        tick();
        do_reset();
        fetch(16'hE001, 1, 1'b0);
        retire(2'd0, 16'h0000, 1, 1'b0);
        repeat (20) tick();
        chk("halt_stays", 16'(halted), 16'd1);
        chk("halt_req_off", 16'(imem_req), 16'd0);
        do_reset();
        chk("restart_addr", imem_addr, RESET_PC);
        for (int k = 0; k < 150; k++) begin
            d = 16'($urandom);
            fetch(d, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            retire(2'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2) == 0);
            if (model_halted) begin
                repeat (3) tick();
                do_reset();
            end
        end
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
